// File: rtl/sevenseg_mux4_ca_capture.sv
// Receive side of a 4-digit common-anode multiplexed 7-segment link: rebuilds BCD digits and value.
// Optional macro CAPTURE_ON_CHANGE_EN: publish only frames that differ from the displayed digits.
module sevenseg_mux4_ca_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd0,
  output logic [13:0] value,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        timeout,
  output logic        link_ok
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [6:0]      seg_m, seg_s;
  logic [3:0]      an_m, an_s;
  logic [10:0]     p, p_prev;
  logic [SW-1:0]   stab_cnt;
  logic [TW-1:0]   to_cnt;
  logic [3:0][3:0] shadow;
  logic [3:0]      seen;
  logic            accept, one_low, dig_ok, wr, bad, complete, publish, to_hit;
  logic [3:0]      dig, wr_mask;
  logic [1:0]      slot;
  logic [13:0]     shadow_value;

  // Idle lines look like a blank display, so the synchronizers start at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_m <= '1;
      seg_s <= '1;
      an_m  <= '1;
      an_s  <= '1;
    end else begin
      seg_m <= seg;
      seg_s <= seg_m;
      an_m  <= an;
      an_s  <= an_m;
    end
  end

  assign p      = {an_s, seg_s};
  assign accept = (p == p_prev) && (stab_cnt == SW'(STABLE_CYCLES - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_prev   <= '1;
      stab_cnt <= '0;
    end else begin
      p_prev <= p;
      if (p != p_prev)
        stab_cnt <= '0;
      else if (stab_cnt != SW'(STABLE_CYCLES - 1))
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_comb begin
    dig_ok = 1'b1;
    dig    = 4'd0;
    case (seg_s)
      7'h40:   dig = 4'd0;
      7'h79:   dig = 4'd1;
      7'h24:   dig = 4'd2;
      7'h30:   dig = 4'd3;
      7'h19:   dig = 4'd4;
      7'h12:   dig = 4'd5;
      7'h02:   dig = 4'd6;
      7'h78:   dig = 4'd7;
      7'h00:   dig = 4'd8;
      7'h10:   dig = 4'd9;
      7'h7F:   dig = 4'd0;
      default: dig_ok = 1'b0;
    endcase
  end

  always_comb begin
    one_low = 1'b1;
    slot    = 2'd0;
    case (an_s)
      4'b0111: slot = 2'd3;
      4'b1011: slot = 2'd2;
      4'b1101: slot = 2'd1;
      4'b1110: slot = 2'd0;
      default: one_low = 1'b0;
    endcase
  end

  assign wr           = accept && one_low && dig_ok;
  assign bad          = accept && one_low && !dig_ok;
  assign wr_mask      = wr ? ~an_s : 4'b0000;
  assign complete     = (seen == 4'b1111);
  assign to_hit       = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign shadow_value = 14'(shadow[3]) * 14'd1000 + 14'(shadow[2]) * 14'd100
                      + 14'(shadow[1]) * 14'd10 + 14'(shadow[0]);

`ifdef CAPTURE_ON_CHANGE_EN
  // fresh forces the first frame after reset or timeout out even if it matches the display
  logic fresh;
  assign publish = complete && (fresh || (shadow != {bcd3, bcd2, bcd1, bcd0}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fresh <= 1'b1;
    else if (publish)
      fresh <= 1'b0;
    else if (to_hit && !complete)
      fresh <= 1'b1;
  end
`else
  assign publish = complete;
`endif

  // Completion takes priority over timeout when both land on the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      seen        <= '0;
      to_cnt      <= '0;
      bcd3        <= '0;
      bcd2        <= '0;
      bcd1        <= '0;
      bcd0        <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      timeout     <= 1'b0;
      link_ok     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
      seg_err     <= bad;
      if (wr)
        shadow[slot] <= dig;
      if (complete) begin
        seen    <= wr_mask;
        to_cnt  <= '0;
        link_ok <= 1'b1;
        if (publish) begin
          {bcd3, bcd2, bcd1, bcd0} <= shadow;
          value       <= shadow_value;
          frame_valid <= 1'b1;
        end
      end else if (to_hit) begin
        seen    <= '0;
        to_cnt  <= '0;
        timeout <= 1'b1;
        link_ok <= 1'b0;
      end else begin
        seen   <= seen | wr_mask;
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule
